frame_buffer_manager: RTL and testbench

- Parametrised successor to the two-buffer BRAM swap manager between ray_marcher (writer) and vga_display (reader).
- Holds NUM_BUFFERS (2 or 3) pixel buffers.
- Tear-free: the front buffer changes only on a display frame boundary.
- In triple-buffer mode the renderer never stalls; a completed frame that is never shown is replaced and counted as dropped.

---
 rtl/frame_buffer_manager.sv | 143 ++++++++++++++
 tb/tb_frame_buffer_manager.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_manager.sv
// Double/triple pixel-buffer swap manager between a frame renderer (writer) and a display (reader).
// The front buffer only moves on vsync, so the display never shows a partially rendered frame.
module frame_buffer_manager #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 57600,
  parameter int ADDR_LEN    = 16,
  parameter int NUM_BUFFERS = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                frame_done_in,
  input  logic                vsync_in,
  input  logic                write_enable_in,
  input  logic [ADDR_LEN-1:0] write_addr_in,
  input  logic [WIDTH-1:0]    write_data_in,
  input  logic [ADDR_LEN-1:0] read_addr_in,
  output logic [WIDTH-1:0]    read_data_out,
  output logic                write_ready_out,
  output logic [1:0]          front_idx_out,
  output logic [1:0]          back_idx_out,
  output logic                ready_valid_out,
  output logic [15:0]         dropped_frames_out
);

  localparam logic [ADDR_LEN:0] DEPTH_W   = (ADDR_LEN + 1)'(DEPTH);
  localparam logic [1:0]        SPARE_RST = 2'(NUM_BUFFERS - 1);

  if (NUM_BUFFERS != 2 && NUM_BUFFERS != 3) begin : g_bad_num_buffers
    $error("frame_buffer_manager: NUM_BUFFERS must be 2 or 3");
  end
  if ((64'd1 << ADDR_LEN) < 64'(DEPTH)) begin : g_bad_addr_len
    $error("frame_buffer_manager: ADDR_LEN too narrow for DEPTH");
  end

  // spare_reg holds READY while ready_valid is set, otherwise FREE (triple mode only)
  logic [1:0]  front_reg, front_next;
  logic [1:0]  back_reg, back_next;
  logic [1:0]  spare_reg, spare_next;
  logic        ready_valid_reg, ready_valid_next;
  logic        write_ready_reg, write_ready_next;
  logic [15:0] dropped_reg, dropped_next;

  always_comb begin
    front_next       = front_reg;
    back_next        = back_reg;
    spare_next       = spare_reg;
    ready_valid_next = ready_valid_reg;
    write_ready_next = write_ready_reg;
    dropped_next     = dropped_reg;
    if (vsync_in && ready_valid_reg) begin
      front_next       = spare_reg;
      ready_valid_next = 1'b0;
      if (NUM_BUFFERS == 3) begin
        spare_next = front_reg;
      end else begin
        back_next        = front_reg;
        write_ready_next = 1'b1;
      end
    end
    // frame_done sees the post-vsync roles but the pre-edge write_ready
    if (frame_done_in && write_ready_reg) begin
      if (NUM_BUFFERS == 3) begin
        back_next  = spare_next;
        spare_next = back_reg;
        if (ready_valid_next && dropped_reg != 16'hFFFF)
          dropped_next = dropped_reg + 16'd1;
        ready_valid_next = 1'b1;
      end else begin
        spare_next       = back_reg;
        ready_valid_next = 1'b1;
        write_ready_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      front_reg       <= 2'd0;
      back_reg        <= 2'd1;
      spare_reg       <= SPARE_RST;
      ready_valid_reg <= 1'b0;
      write_ready_reg <= 1'b1;
      dropped_reg     <= 16'd0;
    end else begin
      front_reg       <= front_next;
      back_reg        <= back_next;
      spare_reg       <= spare_next;
      ready_valid_reg <= ready_valid_next;
      write_ready_reg <= write_ready_next;
      dropped_reg     <= dropped_next;
    end
  end

  logic                wr_en;
  logic                rd_inrange;
  logic [ADDR_LEN-1:0] rd_addr_reg;
  logic [1:0]          rd_idx_reg, rd_idx_q_reg;
  logic                rd_inrange_reg, rd_inrange_q_reg;
  logic [WIDTH-1:0]    mem_q [NUM_BUFFERS];

  assign wr_en      = write_enable_in && write_ready_reg && ({1'b0, write_addr_in} < DEPTH_W);
  assign rd_inrange = {1'b0, read_addr_in} < DEPTH_W;

  // Buffer index travels with the address so a swap mid-read cannot mix frames
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_addr_reg      <= '0;
      rd_idx_reg       <= 2'd0;
      rd_inrange_reg   <= 1'b0;
      rd_idx_q_reg     <= 2'd0;
      rd_inrange_q_reg <= 1'b0;
      read_data_out    <= '0;
    end else begin
      rd_addr_reg      <= rd_inrange ? read_addr_in : '0;
      rd_idx_reg       <= front_reg;
      rd_inrange_reg   <= rd_inrange;
      rd_idx_q_reg     <= rd_idx_reg;
      rd_inrange_q_reg <= rd_inrange_reg;
      read_data_out    <= rd_inrange_q_reg ? mem_q[rd_idx_q_reg] : '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUFFERS; gi++) begin : g_buf
      logic [WIDTH-1:0] mem [DEPTH];
      logic [WIDTH-1:0] q_reg;
      always_ff @(posedge clk_in) begin
        if (wr_en && back_reg == 2'(gi))
          mem[write_addr_in] <= write_data_in;
        q_reg <= mem[rd_addr_reg];
      end
      assign mem_q[gi] = q_reg;
    end
  endgenerate

  assign write_ready_out    = write_ready_reg;
  assign front_idx_out      = front_reg;
  assign back_idx_out       = back_reg;
  assign ready_valid_out    = ready_valid_reg;
  assign dropped_frames_out = dropped_reg;

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Bench for frame_buffer_manager: triple-buffer and double-buffer instances checked every
// cycle against a role-based reference model, plus directed literal checks.
module tb_frame_buffer_manager;

  localparam int D3 = 57600;
  localparam int D2 = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fd3, vs3, we3;
  logic [15:0] wa3, ra3;
  logic [3:0]  wd3, rd3;
  logic        wr3, rv3;
  logic [1:0]  f3, b3;
  logic [15:0] dr3;

  logic        fd2, vs2, we2;
  logic [7:0]  wa2, ra2;
  logic [3:0]  wd2, rd2;
  logic        wr2, rv2;
  logic [1:0]  f2, b2;
  logic [15:0] dr2;

  frame_buffer_manager #(.WIDTH(4), .DEPTH(D3), .ADDR_LEN(16), .NUM_BUFFERS(3)) dut3 (
    .clk_in(clk), .rst_in(rst_n), .frame_done_in(fd3), .vsync_in(vs3),
    .write_enable_in(we3), .write_addr_in(wa3), .write_data_in(wd3),
    .read_addr_in(ra3), .read_data_out(rd3), .write_ready_out(wr3),
    .front_idx_out(f3), .back_idx_out(b3), .ready_valid_out(rv3),
    .dropped_frames_out(dr3));

  frame_buffer_manager #(.WIDTH(4), .DEPTH(D2), .ADDR_LEN(8), .NUM_BUFFERS(2)) dut2 (
    .clk_in(clk), .rst_in(rst_n), .frame_done_in(fd2), .vsync_in(vs2),
    .write_enable_in(we2), .write_addr_in(wa2), .write_data_in(wd2),
    .read_addr_in(ra2), .read_data_out(rd2), .write_ready_out(wr2),
    .front_idx_out(f2), .back_idx_out(b2), .ready_valid_out(rv2),
    .dropped_frames_out(dr2));

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  // Reference model, index 0 = triple instance, 1 = double instance
  int         m_front[2], m_back[2], m_ready[2], m_free[2], m_drop[2];
  bit         m_rv[2], m_wr[2];
  logic [3:0] m_rd[2], m_p1[2];
  bit         m_rdk[2], m_p1k[2], m_p0v[2];
  int         m_p0a[2], m_p0f[2];
  logic [3:0] mmem   [2][3][D3];
  bit         mknown [2][3][D3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int k, input int nb, input int depth, input logic rst_s,
                            input logic fd, input logic vs, input logic we, input int wa,
                            input logic [3:0] wd, input int ra);
    int f, b, r, fr, d, old_front, tmp;
    bit rv, wr, wr_edge;
    // read path: memory is sampled before this edge's write lands
    m_rd[k]  = m_p1[k];
    m_rdk[k] = m_p1k[k];
    if (m_p0v[k]) begin
      m_p1[k]  = mmem[k][m_p0f[k]][m_p0a[k]];
      m_p1k[k] = mknown[k][m_p0f[k]][m_p0a[k]];
    end else begin
      m_p1[k]  = 4'd0;
      m_p1k[k] = 1'b1;
    end
    m_p0v[k] = (ra < depth);
    m_p0a[k] = ra;
    m_p0f[k] = m_front[k];
    if (!rst_s) begin
      m_front[k] = 0; m_back[k] = 1; m_ready[k] = 0; m_free[k] = 2;
      m_rv[k] = 1'b0; m_wr[k] = 1'b1; m_drop[k] = 0;
      m_rd[k] = 4'd0; m_rdk[k] = 1'b1; m_p1[k] = 4'd0; m_p1k[k] = 1'b1; m_p0v[k] = 1'b0;
      return;
    end
    if (we && m_wr[k] && wa < depth) begin
      mmem[k][m_back[k]][wa]   = wd;
      mknown[k][m_back[k]][wa] = 1'b1;
    end
    f = m_front[k]; b = m_back[k]; r = m_ready[k]; fr = m_free[k];
    rv = m_rv[k]; wr = m_wr[k]; d = m_drop[k]; wr_edge = m_wr[k];
    if (vs && rv) begin
      old_front = f;
      f  = r;
      rv = 1'b0;
      if (nb == 3) fr = old_front;
      else begin b = old_front; wr = 1'b1; end
    end
    if (fd && wr_edge) begin
      if (nb == 2) begin
        r = b; rv = 1'b1; wr = 1'b0;
      end else if (!rv) begin
        r = b; b = fr; rv = 1'b1;
      end else begin
        tmp = r; r = b; b = tmp;
        if (d != 65535) d = d + 1;
      end
    end
    m_front[k] = f; m_back[k] = b; m_ready[k] = r; m_free[k] = fr;
    m_rv[k] = rv; m_wr[k] = wr; m_drop[k] = d;
  endtask

  always @(posedge clk) begin
    model_step(0, 3, D3, rst_n, fd3, vs3, we3, int'(wa3), wd3, int'(ra3));
    model_step(1, 2, D2, rst_n, fd2, vs2, we2, int'(wa2), wd2, int'(ra2));
  end

  task automatic cmp_inst(input int k, input logic [3:0] rd, input logic wr, input logic [1:0] f,
                          input logic [1:0] b, input logic rv, input logic [15:0] dr);
    string p;
    p = (k == 0) ? "n3" : "n2";
    check({p, ".front"}, 32'(f), 32'(m_front[k]));
    if (!(k == 1 && !m_wr[1])) check({p, ".back"}, 32'(b), 32'(m_back[k]));
    check({p, ".ready_valid"}, 32'(rv), 32'(m_rv[k]));
    check({p, ".write_ready"}, 32'(wr), 32'(m_wr[k]));
    check({p, ".dropped"}, 32'(dr), 32'(m_drop[k]));
    if (m_rdk[k]) check({p, ".read_data"}, 32'(rd), 32'(m_rd[k]));
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      cmp_inst(0, rd3, wr3, f3, b3, rv3, dr3);
      cmp_inst(1, rd2, wr2, f2, b2, rv2, dr2);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int rand_addr(input int depth);
    if ($urandom_range(15) == 0) return depth - 1 + int'($urandom_range(2));
    return int'($urandom_range(31));
  endfunction

  initial begin
    rst_n = 1'b0;
    fd3 = 0; vs3 = 0; we3 = 0; wa3 = 0; wd3 = 0; ra3 = 0;
    fd2 = 0; vs2 = 0; we2 = 0; wa2 = 0; wd2 = 0; ra2 = 0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    cmp_on = 1'b1;
    check("rst.front", 32'(f3), 32'd0);
    check("rst.back", 32'(b3), 32'd1);
    check("rst.ready_valid", 32'(rv3), 32'd0);
    check("rst.write_ready", 32'(wr3), 32'd1);
    check("rst.dropped", 32'(dr3), 32'd0);
    check("rst.read_data", 32'(rd3), 32'd0);
    check("rst2.write_ready", 32'(wr2), 32'd1);
    $display("txn reset released: front=%0d back=%0d", f3, b3);

    // triple: write, complete, show, read back
    we3 = 1; wa3 = 16'd5; wd3 = 4'hA; tick(1);
    we3 = 0; fd3 = 1; tick(1);
    fd3 = 0; vs3 = 1; tick(1);
    vs3 = 0; ra3 = 16'd5;
    check("basic.front", 32'(f3), 32'd1);
    check("basic.back", 32'(b3), 32'd2);
    tick(3);
    check("basic.read5", 32'(rd3), 32'hA);
    $display("txn basic read addr 5 -> %0h", rd3);

    we3 = 1; wa3 = 16'(D3); wd3 = 4'hF; ra3 = 16'(D3); tick(1);
    we3 = 0; tick(2);
    check("bound.read_depth", 32'(rd3), 32'd0);
    $display("txn read addr DEPTH -> %0h", rd3);

    // two completions without vsync drop one frame
    fd3 = 1; tick(1);
    fd3 = 0; tick(1);
    fd3 = 1; tick(1);
    fd3 = 0;
    check("drop.dropped", 32'(dr3), 32'd1);
    check("drop.ready_valid", 32'(rv3), 32'd1);
    check("drop.write_ready", 32'(wr3), 32'd1);
    check("drop.back", 32'(b3), 32'd2);
    $display("txn drop: dropped=%0d back=%0d", dr3, b3);

    vs3 = 1; fd3 = 1; tick(1);
    vs3 = 0; fd3 = 0;
    check("simul.front", 32'(f3), 32'd0);
    check("simul.back", 32'(b3), 32'd1);
    check("simul.ready_valid", 32'(rv3), 32'd1);
    check("simul.dropped", 32'(dr3), 32'd1);
    $display("txn simultaneous vsync+frame_done: front=%0d back=%0d", f3, b3);

    // double: stall discards writes until vsync
    we2 = 1; wa2 = 8'd7; wd2 = 4'hC; tick(1);
    we2 = 0; fd2 = 1; tick(1);
    fd2 = 0;
    check("stall.write_ready", 32'(wr2), 32'd0);
    check("stall.ready_valid", 32'(rv2), 32'd1);
    we2 = 1; wa2 = 8'd7; wd2 = 4'h3; tick(1);
    we2 = 0; vs2 = 1; tick(1);
    vs2 = 0;
    check("stall.resume", 32'(wr2), 32'd1);
    check("stall.back", 32'(b2), 32'd0);
    check("stall.front", 32'(f2), 32'd1);
    ra2 = 8'd7; tick(3);
    check("stall.read7", 32'(rd2), 32'hC);
    ra2 = 8'(D2); tick(3);
    check("bound2.read_depth", 32'(rd2), 32'd0);
    $display("txn double stall: read addr 7 -> %0h", rd2);

    for (int i = 0; i < 3000; i++) begin
      fd3 = ($urandom_range(7) == 0); vs3 = ($urandom_range(9) == 0);
      we3 = 1'($urandom_range(1)); wa3 = 16'(rand_addr(D3));
      wd3 = 4'($urandom_range(15)); ra3 = 16'(rand_addr(D3));
      fd2 = ($urandom_range(7) == 0); vs2 = ($urandom_range(9) == 0);
      we2 = 1'($urandom_range(1)); wa2 = 8'(rand_addr(D2));
      wd2 = 4'($urandom_range(15)); ra2 = 8'(rand_addr(D2));
      tick(1);
    end
    fd3 = 0; vs3 = 0; we3 = 0; fd2 = 0; vs2 = 0; we2 = 0;
    tick(1);
    $display("txn random phase done: dropped=%0d", dr3);

    fd2 = 1; tick(1);
    fd2 = 0;
    fd3 = 1; tick(65540);
    fd3 = 0; tick(1);
    check("sat.dropped", 32'(dr3), 32'hFFFF);
    check("sat.write_ready", 32'(wr3), 32'd1);
    check("sat.ready_valid", 32'(rv3), 32'd1);
    check("pre_rst2.ready_valid", 32'(rv2), 32'd1);
    $display("txn saturation: dropped=%0h", dr3);

    rst_n = 0; vs3 = 1; fd3 = 1; vs2 = 1; fd2 = 1; tick(1);
    rst_n = 1; vs3 = 0; fd3 = 0; vs2 = 0; fd2 = 0; tick(1);
    check("mid_rst.front", 32'(f3), 32'd0);
    check("mid_rst.back", 32'(b3), 32'd1);
    check("mid_rst.ready_valid", 32'(rv3), 32'd0);
    check("mid_rst.dropped", 32'(dr3), 32'd0);
    check("mid_rst2.front", 32'(f2), 32'd0);
    check("mid_rst2.back", 32'(b2), 32'd1);
    check("mid_rst2.write_ready", 32'(wr2), 32'd1);
    $display("txn reset with ready_valid: front=%0d back=%0d", f3, b3);
    tick(2);

    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
